serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes a single 1-bit full-adder slice across a WIDTH-bit operation. The slice is built from two half-adder cells plus an OR of their carries. The block sequences operand shifting, carry storage and result assembly under a start/done handshake. It is the area-minimal alternative to a ripple array of full adders, for datapaths where latency is cheaper than gates.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain, reset asserts immediately and deasserts synchronously to the design.
- start  input  1  request pulse; sampled on rising edge when state is IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high while an operation is in progress (state ADD).
- done  output  1  one-cycle pulse; high exactly while state is DONE.
- sum  output  WIDTH  registered result; holds the last completed result until the next completion.
- cout  output  1  registered carry-out of the last completed operation.

## Operation
- Datapath: shift registers ra, rb (WIDTH), working result register rs (WIDTH), carry flop c, bit counter cnt (clog2(WIDTH+1) bits), output registers sum/cout.
- Bit slice: HA1(ra[0], rb[0]) → p, g1; HA2(p, c) → s, g2; carry_next = g1 | g2.
- FSM states: IDLE, ADD, DONE.
- IDLE: start=1 → load ra=a, rb=b, c=cin, cnt=0, rs=0 → ADD. start=0 → stay.
- ADD: each edge computes one slice result.
  - rs shifts right with s entering rs[WIDTH-1].
  - ra and rb shift right, zero-filled.
  - c = carry_next; cnt increments.
  - On the edge where cnt == WIDTH-1: sum = final rs (including this bit), cout = carry_next, then → DONE.
- DONE: done=1. start=1 → load as in IDLE and → ADD (back-to-back). Otherwise → IDLE.
- start while in ADD is ignored. Operand changes during ADD have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- WIDTH=1: ADD lasts exactly one edge; same rules apply.
- Reset (any time, including mid-ADD): state=IDLE, busy=0, done=0, sum=0, cout=0, ra/rb/rs/c/cnt=0. The in-flight operation is discarded, and sum/cout do not update with partial results.

## Timing
- Accepting edge = E0. busy rises after E0.
- Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- sum, cout and done update after EWIDTH. done falls after EWIDTH+1 unless a new start is accepted at that edge, in which case busy rises instead.
- Latency from start to done: WIDTH cycles. Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high together.
- sum/cout are stable from the done cycle until the next done cycle.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Reset check: assert rst_n=0 mid-cycle → busy=0, done=0, sum=0x00, cout=0 immediately, with no clock edge required.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start pulse → done high exactly 8 edges after the accepting edge, sum=0x96, cout=0, busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Start 0x12+0x34 → pulse start with a=0xFF, b=0xFF on the 3rd ADD cycle → that pulse is ignored, result 0x46/cout=0; done single pulse; busy not extended.
- Back-to-back: start held high continuously with 0x80+0x80, then 0x01+0x02 presented on the done cycle → first done shows 0x00/cout=1, second op accepted on the DONE edge, next done 9 edges later with 0x03/cout=0.
- Reset mid-operation: start 0x0F+0x01, drop rst_n on the 4th ADD cycle → sum/cout stay 0x00/0, no done pulse. After release, a fresh 0x0F+0x01 → 0x10/cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that reuses one full-adder slice over WIDTH cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, rs, rs_n;
  logic [CW-1:0] cnt;
  logic c, p, g1, s, g2, carry_n, last, load;
  // full adder slice from two half adders
  assign p = ra[0] ^ rb[0];
  assign g1 = ra[0] & rb[0];
  assign s = p ^ c;
  assign g2 = p & c;
  assign carry_n = g1 | g2;
  assign rs_n = (rs >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last = cnt == CW'(WIDTH - 1);
  assign load = start && (state == IDLE || state == DONE);
  assign busy = state == ADD;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = load ? ADD : (state == ADD ? (last ? DONE : ADD) : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        ra <= a;
        rb <= b;
        c <= cin;
        cnt <= '0;
        rs <= '0;
      end else if (state == ADD) begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        rs <= rs_n;
        c <= carry_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          sum <= rs_n;
          cout <= carry_n;
        end
      end
    end
  end
endmodule
